// File: rtl/cpu_write_fifo.sv
`default_nettype none
// =============================================================================
// Module   : cpu_write_fifo
// Purpose  : CPU-mapped byte FIFO (DATA/STATUS registers) feeding a valid/ready consumer.
// Revision : 1.0
// =============================================================================
module cpu_write_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'hE000,
  parameter int          DEPTH     = 16
) (
  input  logic        clk_2,
  input  logic        reset,
  input  logic        cpu_phi2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rwb,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_sel,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int          PTR_W       = $clog2(DEPTH);
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;
  localparam logic [4:0]  DEPTH_CNT   = 5'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty, wr_data, wr_status, pop, push, drop;

  // The strobe is the clk_2 edge that closes the phase-2 high time.
  always_comb begin
    wr_data   = cpu_phi2 && !cpu_rwb && (cpu_addr == BASE_ADDR);
    wr_status = cpu_phi2 && !cpu_rwb && (cpu_addr == STATUS_ADDR);
    full      = (count_q == DEPTH_CNT);
    empty     = (count_q == 5'd0);
    pop       = !empty && out_ready;
    push      = wr_data && (!full || pop);
    drop      = wr_data && full && !pop;

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (wr_status && cpu_data_in[7])
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= cpu_data_in;
  end

  always_comb begin
    out_valid    = !empty;
    out_data     = mem_q[rd_ptr_q];
    cpu_data_sel = cpu_rwb && ((cpu_addr == BASE_ADDR) || (cpu_addr == STATUS_ADDR));
    cpu_data_out = 8'h00;
    if (cpu_data_sel && (cpu_addr == STATUS_ADDR))
      cpu_data_out = {overflow_q, full, empty, count_q};
  end

endmodule
`default_nettype wire

// File: doc/cpu_write_fifo.md
CPU_WRITE_FIFO -- requirements
Module: cpu_write_fifo

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hE000, the CPU address of the DATA register; STATUS sits at BASE_ADDR+1.
REQ-002 The block SHALL have parameter DEPTH, default 16, the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk_2 is the one clock, and reset is synchronous and active-high.
REQ-004 Port clk_2, input, 1 bit: the sole clock, the same clock that toggles cpu_phi2.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cpu_phi2, input, 1 bit: CPU phase-2 clock, toggling every clk_2 rising edge.
REQ-007 Port cpu_addr, input, 16 bits: CPU address bus.
REQ-008 Port cpu_rwb, input, 1 bit: 1 = CPU read, 0 = CPU write.
REQ-009 Port cpu_data_in, input, 8 bits: CPU write data.
REQ-010 Port cpu_data_out, output, 8 bits: read data to the CPU.
REQ-011 Port cpu_data_sel, output, 1 bit: high when this block owns the read data (top-level mux select).
REQ-012 Port out_data, output, 8 bits: FIFO head byte for the downstream consumer.
REQ-013 Port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the head byte.

Function
REQ-015 The block SHALL define the bus strobe as: a clk_2 rising edge where sampled cpu_phi2 = 1, which ends the phase-2 high time; this gives exactly one strobe per CPU cycle.
REQ-016 The block SHALL treat a bus write to DATA as: strobe AND cpu_rwb = 0 AND cpu_addr = BASE_ADDR.
- If not full, or if a pop happens in the same cycle, it SHALL push cpu_data_in.
- Otherwise it SHALL drop the byte and set the overflow flag.
REQ-017 The block SHALL treat a bus write to STATUS as: strobe AND cpu_rwb = 0 AND cpu_addr = BASE_ADDR+1.
- cpu_data_in[7] = 1 SHALL clear the overflow flag.
- All other data bits SHALL be ignored.
REQ-018 The block SHALL drive cpu_data_sel combinationally high when cpu_rwb = 1 and cpu_addr is BASE_ADDR or BASE_ADDR+1, and low otherwise.
REQ-019 The block SHALL return STATUS reads combinationally as {overflow, full, empty, count[4:0]}.
REQ-020 The block SHALL return DATA reads as 8'h00, and such reads SHALL have no side effects.
REQ-021 The block SHALL drive cpu_data_out to 8'h00 whenever cpu_data_sel = 0.
REQ-022 The block SHALL define a pop as out_valid AND out_ready at a clk_2 rising edge; the head entry advances on that edge.
REQ-023 The block SHALL drive out_valid = (count != 0) and out_data = the entry at the read pointer, both from registers with no combinational path from the CPU bus.
REQ-024 The block SHALL register count with width 5 bits, range 0..DEPTH, and update it as follows:
- push only: count+1;
- pop only: count-1;
- push and pop together: unchanged.
REQ-025 The block SHALL use read and write pointers of width log2(DEPTH) that wrap modulo DEPTH with no skipped entry.
REQ-026 The block SHALL derive full = (count = DEPTH) and empty = (count = 0).
REQ-027 When full and a push and pop arrive together, the block SHALL accept both: count stays DEPTH, the new byte is stored, and overflow is not set.
REQ-028 When empty and a push arrives, out_valid SHALL rise on the cycle after the push edge; the latency is 1 clk_2.
REQ-029 The block SHALL ignore writes and reads to addresses other than BASE_ADDR and BASE_ADDR+1, and SHALL ignore bus activity when cpu_phi2 = 0.
REQ-030 The overflow flag SHALL be sticky: it stays set until a STATUS write with bit 7 = 1, or reset.
REQ-031 If a drop and an overflow clear occur in the same cycle (not possible on a single bus cycle), the set SHALL win.

Reset
REQ-032 While reset = 1 at a clk_2 edge, the block SHALL set read pointer = 0, write pointer = 0, count = 0 and overflow = 0.
REQ-033 After reset, out_valid SHALL be 0 and STATUS SHALL read 8'h20; FIFO storage contents are don't-care.
REQ-034 Reset SHALL take priority over any simultaneous push or pop.
REQ-035 Reset asserted mid-stream SHALL discard all entries, and no pop SHALL be reported in that cycle.

Verification
REQ-036 Scenario (reset): assert reset 2 cycles, then read BASE_ADDR+1 -> cpu_data_sel = 1, cpu_data_out = 8'h20, out_valid = 0.
REQ-037 Scenario (single push/pop): CPU writes 8'h41 to BASE_ADDR with out_ready = 0 -> out_valid = 1 and out_data = 8'h41 one cycle later, STATUS = 8'h01; raise out_ready -> after 1 edge out_valid = 0 and STATUS = 8'h20.
REQ-038 Scenario (full and overflow): with out_ready = 0, write 8'h00..8'h0F, then 8'hFF ->
- STATUS = 8'hD0 (overflow, full, count = 16);
- drain yields 8'h00..8'h0F in order;
- 8'hFF is never output.
REQ-039 Scenario (overflow clear): after REQ-038, write 8'h80 to BASE_ADDR+1 -> overflow = 0; writing 8'h00 to BASE_ADDR+1 instead leaves overflow = 1.
REQ-040 Scenario (push and pop when full): FIFO full, out_ready = 1 during a DATA write of 8'hAA -> count stays 16, overflow stays 0, 8'hAA emerges 16th after the current head.
REQ-041 Scenario (wrap, decode and phase): stream 40 bytes with random out_ready -> output order is preserved across pointer wrap; writes to BASE_ADDR+2, and to BASE_ADDR while cpu_phi2 = 0, cause no push.
